// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared CPU fetch parameters and fetch FSM state type
package instr_fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] DEF_TEXT_BASE  = 32'h0000_3000;
    localparam int          DEF_TEXT_WORDS = 4096;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_e;

endpackage

// File: rtl/fetch_range_chk.sv
// fetch_range_chk: flags misaligned or out-of-text-range fetch addresses
module fetch_range_chk
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
    parameter int          TEXT_WORDS = DEF_TEXT_WORDS
) (
    input  logic [31:0] pc,
    output logic        adel
);

    // one bit wider so a text segment ending at the top of memory cannot wrap
    localparam logic [32:0] TEXT_LIMIT = {1'b0, TEXT_BASE} + (33'(TEXT_WORDS) << 2);

    assign adel = (pc[1:0] != 2'b00) || (pc < TEXT_BASE) || ({1'b0, pc} >= TEXT_LIMIT);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC sequencing with branch/exception/eret redirects and fetch qualification
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
    parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
    parameter int          TEXT_WORDS = DEF_TEXT_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_take,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_data,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        fetch_adel
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         bubble_q, bubble_d;

    fetch_range_chk #(
        .TEXT_BASE (TEXT_BASE),
        .TEXT_WORDS(TEXT_WORDS)
    ) u_range_chk (
        .pc  (pc_q),
        .adel(fetch_adel)
    );

    // next PC by priority exc_req > eret > stall > br_take > pc+4; redirects leave a one-cycle bubble
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        bubble_d = bubble_q;
        if (exc_req || eret) begin
            pc_d     = exc_req ? HANDLER_PC : epc;
            bubble_d = 1'b1;
            state_d  = RUN;
        end else if (!stall) begin
            pc_d     = br_take ? br_target : pc_q + 32'd4;
            bubble_d = 1'b0;
            state_d  = RUN;
        end
    end

    // state registers with synchronous active-low reset discarding any pending action
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            bubble_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            bubble_q <= bubble_d;
        end
    end

    assign pc          = pc_q;
    assign im_addr     = ((pc_q - TEXT_BASE) >> 2) & 32'h0000_0FFF;
    assign fetch_valid = (state_q == RUN) && !bubble_q;
    assign instr       = (fetch_valid && !fetch_adel) ? im_data : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset, stall, br_take, exc_req, eret;
    logic [31:0] br_target, epc, im_addr, im_data, instr, pc;
    logic        fetch_valid, fetch_adel;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    // instruction memory returns a tagged copy of the word index
    assign im_data = 32'hA500_0000 | im_addr;

    instr_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_take    (br_take),
        .br_target  (br_target),
        .exc_req    (exc_req),
        .eret       (eret),
        .epc        (epc),
        .im_addr    (im_addr),
        .im_data    (im_data),
        .instr      (instr),
        .pc         (pc),
        .fetch_valid(fetch_valid),
        .fetch_adel (fetch_adel)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; br_take = 0; exc_req = 0; eret = 0;
        br_target = 32'h0; epc = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        tick(); tick();
        n_cmp++; if (pc !== 32'h3000) begin n_bad++; $display("FAIL reset_pc got %h want %h", pc, 32'h3000); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", fetch_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr got %h want 0", instr); end
        n_cmp++; if (fetch_adel !== 1'b0) begin n_bad++; $display("FAIL reset_adel got %b want 0", fetch_adel); end
        n_cmp++; if (im_addr !== 32'h0) begin n_bad++; $display("FAIL reset_imaddr got %h want 0", im_addr); end
        reset = 1;
        tick();
        n_cmp++; if (pc !== 32'h3004) begin n_bad++; $display("FAIL seq1_pc got %h want %h", pc, 32'h3004); end
        n_cmp++; if (fetch_valid !== 1'b1) begin n_bad++; $display("FAIL seq1_valid got %b want 1", fetch_valid); end
        n_cmp++; if (im_addr !== 32'h1) begin n_bad++; $display("FAIL seq1_imaddr got %h want 1", im_addr); end
        n_cmp++; if (instr !== 32'hA500_0001) begin n_bad++; $display("FAIL seq1_instr got %h want %h", instr, 32'hA500_0001); end
        tick();
        n_cmp++; if (pc !== 32'h3008) begin n_bad++; $display("FAIL seq2_pc got %h want %h", pc, 32'h3008); end
        n_cmp++; if (im_addr !== 32'h2) begin n_bad++; $display("FAIL seq2_imaddr got %h want 2", im_addr); end
    endtask

    task automatic test_branch();
        tick(); tick();
        n_cmp++; if (pc !== 32'h3010) begin n_bad++; $display("FAIL pre_br_pc got %h want %h", pc, 32'h3010); end
        br_take = 1; br_target = 32'h3100;
        tick();
        br_take = 0;
        n_cmp++; if (pc !== 32'h3100) begin n_bad++; $display("FAIL br_pc got %h want %h", pc, 32'h3100); end
        n_cmp++; if (im_addr !== 32'h40) begin n_bad++; $display("FAIL br_imaddr got %h want %h", im_addr, 32'h40); end
        n_cmp++; if (fetch_valid !== 1'b1) begin n_bad++; $display("FAIL br_valid got %b want 1", fetch_valid); end
        n_cmp++; if (instr !== 32'hA500_0040) begin n_bad++; $display("FAIL br_instr got %h want %h", instr, 32'hA500_0040); end
    endtask

    task automatic test_stall();
        stall = 1; br_take = 1; br_target = 32'h3200;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (pc !== 32'h3100) begin n_bad++; $display("FAIL stall%0d_pc got %h want %h", i, pc, 32'h3100); end
            n_cmp++; if (fetch_valid !== 1'b1) begin n_bad++; $display("FAIL stall%0d_valid got %b want 1", i, fetch_valid); end
        end
        exc_req = 1;
        tick();
        clear_inputs();
        n_cmp++; if (pc !== 32'h4180) begin n_bad++; $display("FAIL exc_pc got %h want %h", pc, 32'h4180); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL exc_valid got %b want 0", fetch_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL exc_instr got %h want 0", instr); end
        tick();
        n_cmp++; if (pc !== 32'h4184) begin n_bad++; $display("FAIL post_exc_pc got %h want %h", pc, 32'h4184); end
        n_cmp++; if (fetch_valid !== 1'b1) begin n_bad++; $display("FAIL post_exc_valid got %b want 1", fetch_valid); end
    endtask

    task automatic test_eret();
        eret = 1; epc = 32'h3204; br_take = 1; br_target = 32'h3300;
        tick();
        clear_inputs();
        n_cmp++; if (pc !== 32'h3204) begin n_bad++; $display("FAIL eret_pc got %h want %h", pc, 32'h3204); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL eret_valid got %b want 0", fetch_valid); end
        tick();
        n_cmp++; if (pc !== 32'h3208) begin n_bad++; $display("FAIL post_eret_pc got %h want %h", pc, 32'h3208); end
        n_cmp++; if (instr !== 32'hA500_0082) begin n_bad++; $display("FAIL post_eret_instr got %h want %h", instr, 32'hA500_0082); end
        exc_req = 1; eret = 1; epc = 32'h3204;
        tick();
        clear_inputs();
        n_cmp++; if (pc !== 32'h4180) begin n_bad++; $display("FAIL exc_eret_pc got %h want %h", pc, 32'h4180); end
        tick();
    endtask

    task automatic test_adel();
        logic [31:0] tgt [4];
        logic        adel_exp [4];
        logic [31:0] instr_exp [4];
        tgt = '{32'h3002, 32'h2FFC, 32'h7000, 32'h6FFC};
        adel_exp = '{1'b1, 1'b1, 1'b1, 1'b0};
        instr_exp = '{32'h0, 32'h0, 32'h0, 32'hA500_0FFF};
        for (int i = 0; i < 4; i++) begin
            br_take = 1; br_target = tgt[i];
            tick();
            br_take = 0;
            n_cmp++; if (pc !== tgt[i]) begin n_bad++; $display("FAIL adel%0d_pc got %h want %h", i, pc, tgt[i]); end
            n_cmp++; if (fetch_adel !== adel_exp[i]) begin n_bad++; $display("FAIL adel%0d_flag got %b want %b", i, fetch_adel, adel_exp[i]); end
            n_cmp++; if (instr !== instr_exp[i]) begin n_bad++; $display("FAIL adel%0d_instr got %h want %h", i, instr, instr_exp[i]); end
        end
        tick();
        n_cmp++; if (pc !== 32'h7000 || fetch_adel !== 1'b1) begin n_bad++; $display("FAIL adel_limit got pc %h adel %b want 7000/1", pc, fetch_adel); end
    endtask

    task automatic test_wrap();
        br_take = 1; br_target = 32'hFFFF_FFFC;
        tick();
        br_take = 0;
        tick();
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pc got %h want 0", pc); end
        n_cmp++; if (fetch_adel !== 1'b1) begin n_bad++; $display("FAIL wrap_adel got %b want 1", fetch_adel); end
    endtask

    task automatic test_reset_redirect();
        reset = 0; exc_req = 1;
        tick();
        n_cmp++; if (pc !== 32'h3000) begin n_bad++; $display("FAIL rst_exc_pc got %h want %h", pc, 32'h3000); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_bad++; $display("FAIL rst_exc_valid got %b want 0", fetch_valid); end
        clear_inputs();
        reset = 1;
        tick();
        n_cmp++; if (pc !== 32'h3004 || fetch_valid !== 1'b1) begin n_bad++; $display("FAIL boot_exit got pc %h valid %b want 3004/1", pc, fetch_valid); end
        stall = 1; reset = 0;
        tick();
        reset = 1; stall = 0;
        n_cmp++; if (pc !== 32'h3000 || fetch_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stall got pc %h valid %b want 3000/0", pc, fetch_valid); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall();
        test_eret();
        test_adel();
        test_wrap();
        test_reset_redirect();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter HANDLER_PC, default 32'h0000_4180, exception/interrupt entry address.
REQ-003 Parameter TEXT_BASE, default 32'h0000_3000, byte address of instruction-memory word 0.
REQ-004 Parameter TEXT_WORDS, default 4096, instruction-memory depth in words.
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 stall  in  1  hold PC and outputs this cycle.
REQ-008 br_take  in  1  redirect to br_target next edge.
REQ-009 br_target  in  32  branch/jump byte address.
REQ-010 exc_req  in  1  exception/interrupt redirect to HANDLER_PC.
REQ-011 eret  in  1  return redirect to epc.
REQ-012 epc  in  32  return byte address from coprocessor 0.
REQ-013 im_addr  out  32  word index to instruction memory, (pc - TEXT_BASE) >> 2.
REQ-014 im_data  in  32  instruction word returned combinationally by instruction memory.
REQ-015 instr  out  32  fetched instruction to decode stage.
REQ-016 pc  out  32  byte address of instr.
REQ-017 fetch_valid  out  1  instr/pc describe a real fetch.
REQ-018 fetch_adel  out  1  fetch address error (misaligned or outside text range).

Function
REQ-019 PC register SHALL update on each rising edge per priority: exc_req > eret > stall (hold) > br_take > pc+4.
REQ-020 exc_req SHALL override stall; eret SHALL override stall and br_take.
REQ-021 Redirect latency SHALL be one cycle: target appears on pc the edge after the request.
REQ-022 pc+4 SHALL wrap modulo 2^32 with no carry-out.
REQ-023 im_addr SHALL be combinational from pc; only bits [13:2] of the offset carry meaning.
REQ-024 fetch_adel SHALL assert combinationally when pc[1:0] != 0, pc < TEXT_BASE, or pc >= TEXT_BASE + 4*TEXT_WORDS.
REQ-025 When fetch_adel=1, instr SHALL be 32'h0000_0000 (nop) and im_data ignored; pc still reports the faulty address.
REQ-026 FSM states: BOOT, RUN. BOOT occupies exactly the first cycle after reset release, fetch_valid=0, instr=0; BOOT -> RUN unconditionally.
REQ-027 In RUN, fetch_valid SHALL be 1 except in the cycle following an exc_req or eret, when it SHALL be 0 (bubble) and instr=0.
REQ-028 stall SHALL freeze pc, fetch_valid and the FSM state; a redirect arriving during stall is not latched unless it is exc_req or eret.
REQ-029 Simultaneous exc_req and eret SHALL take exc_req.

Reset
REQ-030 While reset=0 at a rising edge: pc=RESET_PC, state=BOOT, fetch_valid=0, instr=0, fetch_adel=0.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard the pending action.

Structure
REQ-032 RESET_PC, HANDLER_PC, TEXT_BASE and TEXT_WORDS defaults belong in the shared CPU parameter include file.
REQ-033 One sub-module, fetch_range_chk (combinational address-error check), is natural; all else in instr_fetch.

Verification
REQ-034 Reset low 2 cycles, release -> pc=0x3000, fetch_valid=0 first cycle, then 0x3004, 0x3008 with fetch_valid=1, im_addr=0,1,2.
REQ-035 br_take=1, br_target=0x3100 at pc=0x3010 -> next pc=0x3100, im_addr=0x40.
REQ-036 stall=1 for 3 cycles with br_take=1 -> pc unchanged throughout; exc_req during stall -> next pc=0x4180, fetch_valid=0 one cycle.
REQ-037 eret=1, epc=0x3204 together with br_take -> next pc=0x3204.
REQ-038 br_target=0x3002, then 0x2FFC, then 0x7000 -> fetch_adel=1, instr=0 each; 0x6FFC -> fetch_adel=0.
REQ-039 reset=0 asserted coincident with exc_req -> pc=0x3000, state BOOT.
